// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and types for vga_sync_gen and pixel_generation.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    localparam int X_MAX = DEF_H_DISPLAY - 1;
    localparam int Y_MAX = DEF_V_DISPLAY - 1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_t;

    function automatic coord_t to_coord(input int value);
        return coord_t'(value);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Divides the system clock by CLK_DIV and emits a one-clk p_tick per pixel.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_next;

    always_comb begin
        div_next = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    end

    // p_tick is registered off div_next so it equals (div_cnt == LAST) yet still reads 0 in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            div_cnt <= div_next;
            p_tick  <= (div_next == LAST);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel counters plus registered hsync/vsync/video_on/frame_tick.
// Define VGA_SYNC_PIPE_EN to delay hsync/vsync by one pixel through a p_tick-enabled stage.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic         clk,
    input  logic         reset,
    output logic         p_tick,
    output logic [9:0]   x,
    output logic [9:0]   y,
    output logic         video_on,
    output logic         hsync,
    output logic         vsync,
    output logic         frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_END      = to_coord(H_TOTAL - 1);
    localparam coord_t V_END      = to_coord(V_TOTAL - 1);
    localparam coord_t H_VIS      = to_coord(H_DISPLAY);
    localparam coord_t V_VIS      = to_coord(V_DISPLAY);
    localparam coord_t H_SS       = to_coord(H_DISPLAY + H_FRONT);
    localparam coord_t H_SE       = to_coord(H_DISPLAY + H_FRONT + H_SYNC);
    localparam coord_t V_SS       = to_coord(V_DISPLAY + V_FRONT);
    localparam coord_t V_SE       = to_coord(V_DISPLAY + V_FRONT + V_SYNC);

    logic hsync_dec;
    logic vsync_dec;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Wrap by explicit compare so non-power-of-two totals never rely on rollover.
    // NOTE: state registers use non-blocking assignments so every decode below sees pre-edge x/y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (p_tick) begin
            if (x == H_END) begin
                x <= '0;
                y <= (y == V_END) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick <= 1'b0;
            video_on   <= 1'b0;
            hsync_dec  <= 1'b1;
            vsync_dec  <= 1'b1;
        end else begin
            frame_tick <= p_tick && (x == H_END) && (y == V_END);
            video_on   <= (x < H_VIS) && (y < V_VIS);
            hsync_dec  <= !((x >= H_SS) && (x < H_SE));
            vsync_dec  <= !((y >= V_SS) && (y < V_SE));
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    sync_t sync_q;

    // Extra pixel of delay keeps the syncs aligned with rgb registered one pixel late.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '{hsync: 1'b1, vsync: 1'b1};
        end else if (p_tick) begin
            sync_q <= '{hsync: hsync_dec, vsync: vsync_dec};
        end
    end

    assign hsync = sync_q.hsync;
    assign vsync = sync_q.vsync;
`else
    assign hsync = hsync_dec;
    assign vsync = vsync_dec;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: three vga_sync_gen instances (full-size and two shrunk rasters) vs a cycle-count model.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    typedef struct packed {
        int d;
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
    } cfg_t;

    localparam cfg_t CFG_A = '{d:4, hd:640, hf:16, hs:96, hb:48, vd:480, vf:10, vs:2, vb:33};
    localparam cfg_t CFG_B = '{d:3, hd:20,  hf:4,  hs:6,  hb:5,  vd:12,  vf:2,  vs:3, vb:4};
    localparam cfg_t CFG_C = '{d:1, hd:8,   hf:2,  hs:3,  hb:2,  vd:4,   vf:1,  vs:2, vb:1};

    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   ka, kb, kc;

    logic       pt_a, von_a, hs_a, vs_a, ft_a;
    logic [9:0] x_a, y_a;
    logic       pt_b, von_b, hs_b, vs_b, ft_b;
    logic [9:0] x_b, y_b;
    logic       pt_c, von_c, hs_c, vs_c, ft_c;
    logic [9:0] x_c, y_c;

    always #5 clk = ~clk;

    vga_sync_gen u_a (
        .clk(clk), .reset(rst_a), .p_tick(pt_a), .x(x_a), .y(y_a),
        .video_on(von_a), .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(3), .V_BACK(4)
    ) u_b (
        .clk(clk), .reset(rst_b), .p_tick(pt_b), .x(x_b), .y(y_b),
        .video_on(von_b), .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) u_c (
        .clk(clk), .reset(rst_c), .p_tick(pt_c), .x(x_c), .y(y_c),
        .video_on(von_c), .hsync(hs_c), .vsync(vs_c), .frame_tick(ft_c)
    );

    // Clock edges seen since each instance's reset release; the model is a pure function of this.
    always @(posedge clk or posedge rst_a) if (rst_a) ka <= 0; else ka <= ka + 1;
    always @(posedge clk or posedge rst_b) if (rst_b) kb <= 0; else kb <= kb + 1;
    always @(posedge clk or posedge rst_c) if (rst_c) kc <= 0; else kc <= kc + 1;

    // ---------------- reference model (closed-form in k) ----------------
    function automatic int h_tot(input cfg_t c); return c.hd + c.hf + c.hs + c.hb; endfunction
    function automatic int v_tot(input cfg_t c); return c.vd + c.vf + c.vs + c.vb; endfunction

    // Pixels advanced after k edges: p_tick is high after edges m>=1 with m%d==d-1.
    function automatic int pix_at(input cfg_t c, input int k);
        if (k <= 0) return 0;
        return k / c.d - ((c.d == 1) ? 1 : 0);
    endfunction
    function automatic int x_at(input cfg_t c, input int k);
        return pix_at(c, k) % h_tot(c);
    endfunction
    function automatic int y_at(input cfg_t c, input int k);
        return (pix_at(c, k) / h_tot(c)) % v_tot(c);
    endfunction
    function automatic bit pt_at(input cfg_t c, input int k);
        return (k >= 1) && (k % c.d == c.d - 1);
    endfunction
    function automatic bit hs_dec(input cfg_t c, input int k);
        int xv;
        if (k <= 0) return 1'b1;
        xv = x_at(c, k - 1);
        return !(xv >= c.hd + c.hf && xv < c.hd + c.hf + c.hs);
    endfunction
    function automatic bit vs_dec(input cfg_t c, input int k);
        int yv;
        if (k <= 0) return 1'b1;
        yv = y_at(c, k - 1);
        return !(yv >= c.vd + c.vf && yv < c.vd + c.vf + c.vs);
    endfunction
    function automatic bit von_at(input cfg_t c, input int k);
        if (k <= 0) return 1'b0;
        return (x_at(c, k - 1) < c.hd) && (y_at(c, k - 1) < c.vd);
    endfunction
    function automatic bit ft_at(input cfg_t c, input int k);
        if (k <= 0) return 1'b0;
        return pt_at(c, k - 1) && x_at(c, k - 1) == h_tot(c) - 1 && y_at(c, k - 1) == v_tot(c) - 1;
    endfunction
    // Latest state index before k in which p_tick was high, or -1 if none yet.
    function automatic int last_tick(input cfg_t c, input int k);
        int t;
        t = k - 1;
        if (c.d == 1) return (t >= 1) ? t : -1;
        if (t < c.d - 1) return -1;
        return t - ((t - (c.d - 1)) % c.d);
    endfunction
    function automatic bit hs_out(input cfg_t c, input int k);
`ifdef VGA_SYNC_PIPE_EN
        int m;
        m = last_tick(c, k);
        return (m < 0) ? 1'b1 : hs_dec(c, m);
`else
        return hs_dec(c, k);
`endif
    endfunction
    function automatic bit vs_out(input cfg_t c, input int k);
`ifdef VGA_SYNC_PIPE_EN
        int m;
        m = last_tick(c, k);
        return (m < 0) ? 1'b1 : vs_dec(c, m);
`else
        return vs_dec(c, k);
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string p, input cfg_t c, input int k,
                             input logic pt, input logic [9:0] xv, input logic [9:0] yv,
                             input logic von, input logic hs, input logic vs, input logic ft);
        check({p, "_p_tick"},     {31'd0, pt},  {31'd0, pt_at(c, k)});
        check({p, "_x"},          {22'd0, xv},  x_at(c, k));
        check({p, "_y"},          {22'd0, yv},  y_at(c, k));
        check({p, "_video_on"},   {31'd0, von}, {31'd0, von_at(c, k)});
        check({p, "_hsync"},      {31'd0, hs},  {31'd0, hs_out(c, k)});
        check({p, "_vsync"},      {31'd0, vs},  {31'd0, vs_out(c, k)});
        check({p, "_frame_tick"}, {31'd0, ft},  {31'd0, ft_at(c, k)});
    endtask

    always @(negedge clk) begin
        check_all("A", CFG_A, ka, pt_a, x_a, y_a, von_a, hs_a, vs_a, ft_a);
        check_all("B", CFG_B, kb, pt_b, x_b, y_b, von_b, hs_b, vs_b, ft_b);
        check_all("C", CFG_C, kc, pt_c, x_c, y_c, von_c, hs_c, vs_c, ft_c);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + randomized stimulus ----------------
    initial begin
        int n, lows, highs, ticks, frame_len;

        // Step 1: reset held 10 clks, release between edges.
        repeat (10) @(negedge clk);
        #2 rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        @(negedge clk);
        check("rel_video_on", {31'd0, von_a}, 1);
        check("rel_hsync",    {31'd0, hs_a},  1);
        check("rel_vsync",    {31'd0, vs_a},  1);
        n = 1;
        while (!pt_a && n < 20) begin @(negedge clk); n++; end
        // First p_tick is seen after CLK_DIV-1 edges, i.e. during the CLK_DIV-th clk.
        check("first_ptick_edge", n, CFG_A.d - 1);
        @(negedge clk);
        check("x_after_first_tick", {22'd0, x_a}, 1);

        // Step 2: one line of A - hsync low window and line wrap.
        n = 0;
        while (hs_a && n < 4000) begin @(negedge clk); n++; end
        check("hsync_fall_timeout", {31'd0, n < 4000}, 1);
`ifdef VGA_SYNC_PIPE_EN
        check("hsync_fall_x", {22'd0, x_a}, 657);
`else
        check("hsync_fall_x", {22'd0, x_a}, 656);
`endif
        lows = 0;
        while (!hs_a && lows < 1000) begin @(negedge clk); lows++; end
        check("hsync_low_clks", lows, 384);
        n = 0;
        while (x_a != 0 && n < 4000) begin @(negedge clk); n++; end
        check("line_wrap_y", {22'd0, y_a}, 1);

        // Visible-window right edge: video_on lags x by one clk.
        n = 0;
        while (x_a != 640 && n < 4000) begin @(negedge clk); n++; end
        check("von_first_clk_x640", {31'd0, von_a}, 1);
        @(negedge clk);
        check("von_x640", {31'd0, von_a}, 0);

        // Step 3: full frame of B - vsync width, frame_tick spacing, visible count.
        n = 0;
        while (vs_b && n < 5000) begin @(negedge clk); n++; end
        check("vsync_fall_timeout", {31'd0, n < 5000}, 1);
        lows = 0;
        while (!vs_b && lows < 1000) begin @(negedge clk); lows++; end
        check("vsync_low_clks", lows, CFG_B.vs * h_tot(CFG_B) * CFG_B.d);
        n = 0;
        while (!ft_b && n < 5000) begin @(negedge clk); n++; end
        check("frame_tick_timeout", {31'd0, n < 5000}, 1);
        frame_len = 0; highs = 0; ticks = 0;
        do begin
            if (von_b) highs++;
            if (ft_b) ticks++;
            @(negedge clk);
            frame_len++;
        end while (!ft_b && frame_len < 5000);
        check("frame_len_clks", frame_len, h_tot(CFG_B) * v_tot(CFG_B) * CFG_B.d);
        check("frame_tick_count", ticks, 1);
        check("video_on_clks", highs, CFG_B.hd * CFG_B.vd * CFG_B.d);

        // Step 4: CLK_DIV==1 keeps p_tick high continuously.
        ticks = 0;
        for (int i = 0; i < 50; i++) begin
            if (pt_c) ticks++;
            @(negedge clk);
        end
        check("div1_ptick_count", ticks, 50);

        // Step 5: async reset of A mid-line at x=300.
        n = 0;
        while (x_a != 300 && n < 4000) begin @(negedge clk); n++; end
        check("x300_timeout", {31'd0, n < 4000}, 1);
        #2 rst_a = 1'b1;
        #1;
        check("async_x",          {22'd0, x_a},  0);
        check("async_y",          {22'd0, y_a},  0);
        check("async_p_tick",     {31'd0, pt_a}, 0);
        check("async_video_on",   {31'd0, von_a}, 0);
        check("async_hsync",      {31'd0, hs_a}, 1);
        check("async_vsync",      {31'd0, vs_a}, 1);
        check("async_frame_tick", {31'd0, ft_a}, 0);
        repeat ($urandom_range(1, 6)) @(negedge clk);
        #2 rst_a = 1'b0;
        @(negedge clk);
        check("resume_x", {22'd0, x_a}, 0);
        check("resume_y", {22'd0, y_a}, 0);

        // Randomized async resets of B at arbitrary raster positions.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(100, 1500)) @(negedge clk);
            #($urandom_range(1, 4)) rst_b = 1'b1;
            #1;
            check("rand_rst_x",     {22'd0, x_b},  0);
            check("rand_rst_hsync", {31'd0, hs_b}, 1);
            repeat ($urandom_range(1, 5)) @(negedge clk);
            #($urandom_range(1, 4)) rst_b = 1'b0;
        end
        repeat (2 * h_tot(CFG_B) * v_tot(CFG_B) * CFG_B.d + 10) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
